// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures core register-writeback events into a FIFO
// for a host to drain, with overflow tracking and a running checksum.
module wb_trace_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_valid,
    input  logic [4:0]    wb_reg,
    input  logic [31:0]   wb_data,
    input  logic [31:0]   wb_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [4:0]    out_reg,
    output logic [31:0]   out_data,
    output logic [31:0]   out_pc,
    output logic [CW-1:0] count,
    output logic          overflow,
    output logic [15:0]   drop_count,
    output logic [31:0]   checksum,
    input  logic          clear
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          qual;
    logic          pop;
    logic          full;
    logic          capture;
    logic          drop;
    logic [31:0]   cs_base;

    assign head      = mem[rd_ptr];
    assign out_reg   = head.rd;
    assign out_data  = head.data;
    assign out_pc    = head.pc;
    assign out_valid = (count != '0);

    // A full FIFO still accepts an event when the head leaves the same cycle.
    assign qual    = wb_valid && (wb_reg != 5'd0);
    assign pop     = out_valid && out_ready;
    assign full    = (count == CW'(DEPTH));
    assign capture = qual && (!full || pop);
    assign drop    = qual && !capture;
    assign cs_base = clear ? 32'h0 : {checksum[30:0], checksum[31]};

    // Entry storage is not reset; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (capture) begin
            mem[wr_ptr] <= '{rd: wb_reg, data: wb_data, pc: wb_pc};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 16'h0;
            checksum   <= 32'h0;
        end else begin
            if (capture) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(capture) - CW'(pop);

            // Clear wins over history but not over a drop in the same cycle.
            if (clear) begin
                overflow   <= drop;
                drop_count <= drop ? 16'd1 : 16'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) begin
                    drop_count <= drop_count + 16'd1;
                end
            end

            if (capture) begin
                checksum <= cs_base ^ wb_data ^ {27'b0, wb_reg};
            end else if (clear) begin
                checksum <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: a reference queue model predicts every
// output each cycle; directed scenarios plus a random stretch.
module tb_wb_trace_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          wb_valid;
    logic [4:0]    wb_reg;
    logic [31:0]   wb_data;
    logic [31:0]   wb_pc;
    logic          out_valid;
    logic          out_ready;
    logic [4:0]    out_reg;
    logic [31:0]   out_data;
    logic [31:0]   out_pc;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   drop_count;
    logic [31:0]   checksum;
    logic          clear;

    wb_trace_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_pc(wb_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_reg(out_reg), .out_data(out_data), .out_pc(out_pc),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .checksum(checksum), .clear(clear)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] p;
    } ev_t;

    ev_t         q[$];
    bit          m_ovf;
    int          m_drops;
    logic [31:0] m_cs;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_state();
        check("count", 32'(count), 32'(q.size()));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("head_reg", 32'(out_reg), 32'(q[0].r));
            check("head_data", out_data, q[0].d);
            check("head_pc", out_pc, q[0].p);
        end
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("drop_count", 32'(drop_count), 32'(m_drops));
        check("checksum", checksum, m_cs);
    endtask

    task automatic cycle(input logic wv, input logic [4:0] r, input logic [31:0] d,
                         input logic [31:0] p, input logic rdy, input logic clr);
        bit qual, pop, cap, drp;
        wb_valid  = wv;
        wb_reg    = r;
        wb_data   = d;
        wb_pc     = p;
        out_ready = rdy;
        clear     = clr;
        qual = wv && (r != 5'd0);
        pop  = (q.size() != 0) && rdy;
        cap  = qual && ((q.size() < DEPTH) || pop);
        drp  = qual && !cap;
        if (pop) void'(q.pop_front());
        if (cap) q.push_back('{r, d, p});
        if (clr) begin
            m_ovf   = drp;
            m_drops = drp ? 1 : 0;
        end else if (drp) begin
            m_ovf = 1'b1;
            if (m_drops < 65535) m_drops++;
        end
        if (cap) m_cs = (clr ? 32'h0 : {m_cs[30:0], m_cs[31]}) ^ d ^ {27'b0, r};
        else if (clr) m_cs = 32'h0;
        @(posedge clk);
        #1;
        compare_state();
    endtask

    // Reset with arbitrary other inputs active; reset must override them.
    task automatic do_reset(input logic wv, input logic rdy, input logic clr);
        reset     = 1'b1;
        wb_valid  = wv;
        wb_reg    = 5'd7;
        wb_data   = 32'hDEAD_BEEF;
        wb_pc     = 32'h0000_1000;
        out_ready = rdy;
        clear     = clr;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        m_cs    = 32'h0;
        compare_state();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; wb_valid = 1'b0; wb_reg = 5'd0; wb_data = 32'h0; wb_pc = 32'h0;
        out_ready = 1'b0; clear = 1'b0;
        m_ovf = 1'b0; m_drops = 0; m_cs = 32'h0;
        @(posedge clk);
        do_reset(1'b0, 1'b0, 1'b0);

        // Single event, one-cycle latency, known checksum
        cycle(1'b1, 5'd5, 32'h0000_00AA, 32'h0040_0000, 1'b0, 1'b0);
        check("r034_valid", 32'(out_valid), 32'd1);
        check("r034_reg", 32'(out_reg), 32'd5);
        check("r034_data", out_data, 32'h0000_00AA);
        check("r034_count", 32'(count), 32'd1);
        check("r034_cs", checksum, 32'h0000_00AF);
        drain(2);

        // x0 writes are ignored entirely
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'd0, $urandom, $urandom, 1'b0, 1'b0);
        check("r035_count", 32'(count), 32'd0);
        check("r035_cs", checksum, 32'd0);
        check("r035_drops", 32'(drop_count), 32'd0);

        // Overfill: 20 events into 16 entries
        do_reset(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++)
            cycle(1'b1, 5'(i % 31 + 1), 32'(i), 32'h0040_0000 + 32'(4 * i), 1'b0, 1'b0);
        check("r036_count", 32'(count), 32'd16);
        check("r036_ovf", 32'(overflow), 32'd1);
        check("r036_drops", 32'(drop_count), 32'd4);

        // Full with same-cycle pop: event captured, no drop
        cycle(1'b1, 5'd9, 32'h0000_0BEE, 32'h0040_1000, 1'b1, 1'b0);
        check("r037_count", 32'(count), 32'd16);
        check("r037_drops", 32'(drop_count), 32'd4);
        drain(18);

        // Clear alone, clear with drop, clear with capture
        cycle(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 5'd3, 32'(i * 7), 32'(i), 1'b0, 1'b0);
        cycle(1'b1, 5'd4, 32'h1234, 32'h0, 1'b0, 1'b1);
        check("clr_drop_drops", 32'(drop_count), 32'd1);
        check("clr_drop_ovf", 32'(overflow), 32'd1);
        cycle(1'b1, 5'd6, 32'h0000_5555, 32'h0, 1'b1, 1'b1);
        check("clr_cap_cs", checksum, 32'h0000_5553);
        drain(18);

        // Streaming: 40 events with continuous pop, wraps pointers twice
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 5'(i % 31 + 1), 32'hA000_0000 + 32'(i), 32'(i * 4), 1'b1, 1'b0);
        check("r038_ovf", 32'(overflow), 32'd0);
        drain(3);

        // Reset mid-operation with other inputs active
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'd10, 32'(i), 32'(i), 1'b0, 1'b0);
        do_reset(1'b1, 1'b1, 1'b1);
        check("r039_count", 32'(count), 32'd0);
        check("r039_valid", 32'(out_valid), 32'd0);
        check("r039_cs", checksum, 32'd0);

        // Random traffic in alternating fill/drain-biased phases
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom, $urandom,
                  ((i / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 24) == 0);
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries, power of two, 2..256, SHALL be supported.
REQ-002 Parameter CW, default $clog2(DEPTH)+1, count width, SHALL be supported.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 wb_valid  input  1  core writeback event this cycle.
REQ-006 wb_reg  input  5  destination register of the event.
REQ-007 wb_data  input  32  value written.
REQ-008 wb_pc  input  32  PC of the retiring instruction.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  host accepts head entry.
REQ-011 out_reg / out_data / out_pc  output  5/32/32  head entry fields.
REQ-012 count  output  CW  entries held, 0..DEPTH.
REQ-013 overflow  output  1  sticky, an event was dropped.
REQ-014 drop_count  output  16  dropped events, saturating.
REQ-015 checksum  output  32  running signature of captured events.
REQ-016 clear  input  1  clears overflow, drop_count, checksum; FIFO contents untouched.

Function
REQ-017 Event SHALL be qualified when wb_valid=1 and wb_reg!=0; wb_reg=0 events SHALL be ignored entirely (no capture, no drop, no checksum change).
REQ-018 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 Qualified event SHALL be captured when count<DEPTH, or when count=DEPTH and a pop occurs the same cycle.
REQ-020 Qualified event not captured SHALL set overflow and increment drop_count, holding at 16'hFFFF.
REQ-021 Captured event SHALL appear at out_* no earlier than the next cycle; empty-FIFO latency exactly 1 cycle wb_valid -> out_valid.
REQ-022 out_* SHALL reflect the oldest entry; order SHALL be strictly FIFO.
REQ-023 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 out_valid SHALL equal (count!=0).
REQ-025 Simultaneous capture and pop: count unchanged; both pointers advance.
REQ-026 Pointers SHALL wrap modulo DEPTH without gaps.
REQ-027 out_ready while empty SHALL have no effect.
REQ-028 On capture: checksum <= {checksum[30:0],checksum[31]} ^ wb_data ^ {27'b0,wb_reg}.
REQ-029 clear=1 with a same-cycle capture: checksum SHALL load 32'h0 ^ wb_data ^ {27'b0,wb_reg}; a same-cycle drop SHALL leave overflow=1, drop_count=1.
REQ-030 Otherwise clear SHALL zero overflow, drop_count, checksum next cycle.

Reset
REQ-031 reset=1 SHALL force next cycle: count=0, out_valid=0, pointers=0, overflow=0, drop_count=0, checksum=0.
REQ-032 reset SHALL override all inputs including same-cycle wb_valid, out_ready, clear.
REQ-033 Reset mid-operation SHALL discard all entries; out_reg/out_data/out_pc contents are don't-care while out_valid=0.

Verification
REQ-034 Reset then single event (reg 5, data 32'h0000_00AA, pc 32'h0040_0000), out_ready=0 -> next cycle out_valid=1, out_reg=5, out_data=32'hAA, count=1, checksum=32'h0000_00AF.
REQ-035 wb_reg=0 with wb_valid=1 for 10 cycles -> count=0, checksum=0, drop_count=0.
REQ-036 DEPTH=16, out_ready=0, 20 qualified events -> count=16, overflow=1, drop_count=4; draining returns events 1..16 in order.
REQ-037 Full FIFO, out_ready=1 and qualified event same cycle -> count stays 16, drop_count unchanged, new event emerges last.
REQ-038 Continuous push/pop for 40 events -> no drops, pointer wrap exercised twice, output sequence matches input.
REQ-039 Three queued entries, assert reset for one cycle -> count=0, out_valid=0, overflow=0, drop_count=0, checksum=0 next cycle.
